// File: rtl/sync_arith_pkg.sv
// sync_arith_pkg: opcode and status-bit constants for the registered arithmetic unit
package sync_arith_pkg;
    localparam int OP_SUB2B = 0;
    localparam int OP_LT    = 1;
    localparam int OP_ADD   = 2;
    localparam int OP_U2ZM  = 3;
    localparam int ST_ERR   = 3;
    localparam int ST_ONES  = 2;
    localparam int ST_ZEROS = 1;
    localparam int ST_PAR   = 0;
endpackage

// File: rtl/sync_arith_core.sv
// sync_arith_core: combinational next result, error and flags for one signed op
module sync_arith_core
    import sync_arith_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic [N-1:0] i_op,
    input  logic [M-1:0] i_arg_A,
    input  logic [M-1:0] i_arg_B,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);
    logic signed [M+1:0] w_a, w_b, w_sub, w_add;
    logic [M-2:0] w_mag;
    logic [M-1:0] w_sm, w_r;
    logic w_sub_ovf, w_add_ovf, w_lt, w_a_min, w_hi, w_err;
    logic [1:0] w_op;
    assign w_op  = i_op[1:0];
    assign w_a   = {{2{i_arg_A[M-1]}}, i_arg_A};
    assign w_b   = {{2{i_arg_B[M-1]}}, i_arg_B};
    assign w_sub = w_a - (w_b <<< 1);
    assign w_add = w_a + w_b;
    // a value fits in M bits only when its top three bits agree
    assign w_sub_ovf = ~((&w_sub[M+1:M-1]) | ~(|w_sub[M+1:M-1]));
    assign w_add_ovf = ~((&w_add[M+1:M-1]) | ~(|w_add[M+1:M-1]));
    assign w_lt    = $signed(i_arg_A) < $signed(i_arg_B);
    // low M-1 bits of |A| depend only on the low M-1 bits of A
    assign w_mag   = -i_arg_A[M-2:0];
    assign w_a_min = i_arg_A[M-1] & ~(|i_arg_A[M-2:0]);
    assign w_sm    = i_arg_A[M-1] ? {1'b1, w_mag} : i_arg_A;
    if (N > 2) begin : g_hi
        assign w_hi = |i_op[N-1:2];
    end else begin : g_no_hi
        assign w_hi = 1'b0;
    end
    assign w_err = w_hi
                 | (w_op == 2'(OP_SUB2B) & w_sub_ovf)
                 | (w_op == 2'(OP_ADD)   & w_add_ovf)
                 | (w_op == 2'(OP_U2ZM)  & w_a_min);
    assign w_r = (w_op == 2'(OP_SUB2B)) ? w_sub[M-1:0] :
                 (w_op == 2'(OP_LT))    ? {{(M-1){1'b0}}, w_lt} :
                 (w_op == 2'(OP_ADD))   ? w_add[M-1:0] : w_sm;
    // error forces a zero result and suppresses every flag except ERROR
    always_comb begin
        o_status           = '0;
        o_result           = w_err ? '0 : w_r;
        o_status[ST_ERR]   = w_err;
        o_status[ST_ONES]  = ~w_err & (&w_r);
        o_status[ST_ZEROS] = ~w_err & ~(|w_r);
        o_status[ST_PAR]   = ~w_err & (^w_r);
    end
endmodule

// File: rtl/sync_arith_unit.sv
// sync_arith_unit: registered signed ALU with result and status flags, one-cycle latency
module sync_arith_unit
    import sync_arith_pkg::*;
#(
    parameter int N = 2,
    parameter int M = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_op,
    input  logic [M-1:0] i_arg_A,
    input  logic [M-1:0] i_arg_B,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);
    logic [M-1:0] w_result, r_result;
    logic [3:0]   w_status, r_status;
    sync_arith_core #(.N(N), .M(M)) u_core (
        .i_op     (i_op),
        .i_arg_A  (i_arg_A),
        .i_arg_B  (i_arg_B),
        .o_result (w_result),
        .o_status (w_status)
    );
    // capture every cycle; active-low reset clears outputs without waiting for a clock
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_result <= '0;
            r_status <= '0;
        end else begin
            r_result <= w_result;
            r_status <= w_status;
        end
    end
    assign o_result = r_result;
    assign o_status = r_status;
endmodule

// File: tb/tb_sync_arith_unit.sv
// tb_sync_arith_unit: directed vectors with a queue scoreboard checked by a separate monitor
module tb_sync_arith_unit;
    logic       clk = 1'b0;
    bit         clk_en = 1'b1;
    logic       rst_n;
    logic [1:0] op;
    logic [3:0] a, b;
    logic [3:0] result, status;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    logic [7:0] last_exp;

    sync_arith_unit #(.N(2), .M(4)) dut (
        .i_clk    (clk),
        .i_reset  (rst_n),
        .i_op     (op),
        .i_arg_A  (a),
        .i_arg_B  (b),
        .o_result (result),
        .o_status (status)
    );

    always #5 if (clk_en) clk = ~clk;

    // monitor: every edge presents the response to the inputs driven one half-cycle earlier
    always @(posedge clk) begin
        if (sb.size() > 0) begin
            logic [7:0] e;
            e = sb.pop_front();
            #1;
            checks++;
            if ({result, status} !== e) begin
                failures++;
                $display("FAIL op_result got=%b/%b exp=%b/%b", result, status, e[7:4], e[3:0]);
            end
        end
    end

    task automatic send(input int o, input int x, input int y, input logic [3:0] r, input logic [3:0] s);
        @(negedge clk);
        op = 2'(o);
        a = 4'(x);
        b = 4'(y);
        sb.push_back({r, s});
        last_exp = {r, s};
    endtask

    task automatic check_now(input string name, input logic [7:0] e);
        checks++;
        if ({result, status} !== e) begin
            failures++;
            $display("FAIL %s got=%b/%b exp=%b/%b", name, result, status, e[7:4], e[3:0]);
        end
    endtask

    task automatic drain;
        int n = 0;
        while (sb.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        if (sb.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        #1 check_now("reset_initial", 8'h00);
        @(negedge clk) rst_n = 1'b1;
        send(2, 2, 3, 4'b0101, 4'b0000);
        send(0, 3, 1, 4'b0001, 4'b0001);
        send(0, 3, -1, 4'b0101, 4'b0000);
        send(0, 4, 2, 4'b0000, 4'b0010);
        send(0, 7, 2, 4'b0011, 4'b0000);
        send(0, 4, 3, 4'b1110, 4'b0001);
        send(0, 2, -3, 4'b0000, 4'b1000);
        send(1, 3, 5, 4'b0001, 4'b0001);
        send(1, -4, 3, 4'b0001, 4'b0001);
        send(1, -3, -3, 4'b0000, 4'b0010);
        send(1, 4, -5, 4'b0000, 4'b0010);
        send(2, 1, 1, 4'b0010, 4'b0001);
        send(2, 6, 1, 4'b0111, 4'b0001);
        send(2, 7, 1, 4'b0000, 4'b1000);
        send(2, -8, -1, 4'b0000, 4'b1000);
        send(2, -1, 0, 4'b1111, 4'b0100);
        send(3, -5, 5, 4'b1101, 4'b0001);
        send(3, 0, -2, 4'b0000, 4'b0010);
        send(3, -7, 7, 4'b1111, 4'b0100);
        send(3, 3, -8, 4'b0011, 4'b0000);
        send(3, -8, 1, 4'b0000, 4'b1000);
        send(2, -1, 0, 4'b1111, 4'b0100);
        drain();
        // outputs are 1111/0100 here, so a clear proves the reset path is asynchronous
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_now("reset_async", 8'h00);
        @(negedge clk) rst_n = 1'b1;
        send(0, -1, 3, 4'b1001, 4'b0000);
        drain();
        @(negedge clk) clk_en = 1'b0;
        #50 check_now("hold_clock_stopped", last_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
